// File: rtl/div_pkg.sv
// Shared types and helpers for the restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Width of the step counter that walks 0..n-1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/restoring_divider_n_bit_if.sv
// Start/done handshake and operand/result bundle for the restoring divider.
interface restoring_divider_n_bit_if #(
  parameter int unsigned N = 8
);

  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/sub_n_bit.sv
// W-bit ripple-borrow subtractor: diff = a - b, borrow_out set when a < b.
module sub_n_bit #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  logic [W:0] bw;

  assign bw[0] = 1'b0;

  // One full-subtractor slice per bit, borrow rippling toward the MSB.
  for (genvar i = 0; i < W; i++) begin : g_fs
    assign diff[i]  = a[i] ^ b[i] ^ bw[i];
    assign bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
  end

  assign borrow_out = bw[W];

endmodule

// File: rtl/restoring_divider_n_bit.sv
// Unsigned N-bit sequential restoring divider, one trial subtraction per clock.
module restoring_divider_n_bit
  import div_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  restoring_divider_n_bit_if.slave  bus
);

  localparam int unsigned CW = cnt_w(N);
  localparam int unsigned PW = N + 1;

  div_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0]  d, d_n;
  logic [N-1:0]  dv, dv_n;
  logic [PW-1:0] r, r_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;
  logic [N-1:0]  quo_q, quo_n;
  logic [N-1:0]  rem_q, rem_n;
  logic          dbz_q, dbz_n;

  logic [PW-1:0] p;
  logic [PW-1:0] diff;
  logic          borrow;

  // Shift the next dividend bit into the partial remainder; r[N] is always 0 here.
  assign p = PW'({r, d[N-1]});

  sub_n_bit #(.W(PW)) u_sub (
    .a          (p),
    .b          ({1'b0, dv}),
    .diff       (diff),
    .borrow_out (borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      d      <= '0;
      dv     <= '0;
      r      <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      d      <= d_n;
      dv     <= dv_n;
      r      <= r_n;
      busy_q <= busy_n;
      done_q <= done_n;
      quo_q  <= quo_n;
      rem_q  <= rem_n;
      dbz_q  <= dbz_n;
    end
  end

  // Next-state and next-register logic; d doubles as the quotient shift register.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    d_n     = d;
    dv_n    = dv;
    r_n     = r;
    quo_n   = quo_q;
    rem_n   = rem_q;
    dbz_n   = dbz_q;

    unique case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (bus.start) begin
          if (bus.divisor != '0) begin
            state_n = CALC;
            d_n     = bus.dividend;
            dv_n    = bus.divisor;
            r_n     = '0;
            cnt_n   = '0;
            dbz_n   = 1'b0;
          end else begin
            state_n = DONE;
            quo_n   = '1;
            rem_n   = bus.dividend;
            dbz_n   = 1'b1;
          end
        end
      end
      CALC: begin
        r_n   = borrow ? p : diff;
        d_n   = {d[N-2:0], ~borrow};
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(N - 1)) begin
          state_n = DONE;
          quo_n   = d_n;
          rem_n   = r_n[N-1:0];
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == CALC);
    done_n = (state_n == DONE);
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_n_bit.sv
// Randomized self-checking bench for restoring_divider_n_bit against plain / and %.
module tb_restoring_divider_n_bit;

  localparam int unsigned N = 8;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;
  logic [N-1:0] last_q;
  logic [N-1:0] last_r;

  restoring_divider_n_bit_if #(.N(N)) bus ();

  restoring_divider_n_bit #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one cycle; returns just after the accepting edge.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    step();
    bus.start    = 1'b0;
  endtask

  // Wait for done and compare against arithmetic; glitch >= 0 pulses a bogus start mid-run.
  task automatic wait_result(input logic [N-1:0] a, input logic [N-1:0] b, input int glitch);
    int i;
    int busy_cnt;
    logic [N-1:0] eq, er;
    logic ez;
    if (b == '0) begin
      eq = '1; er = a; ez = 1'b1;
    end else begin
      eq = a / b; er = a % b; ez = 1'b0;
    end
    i = 0;
    busy_cnt = 0;
    while (!bus.done && i < 40) begin
      if (bus.busy) busy_cnt++;
      if (i == glitch) begin
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd5;
      end
      step();
      bus.start = 1'b0;
      i++;
    end
    chk($sformatf("latency %0d/%0d", a, b), 32'(i), (b == '0) ? 32'd0 : 32'(N));
    chk($sformatf("busy_cycles %0d/%0d", a, b), 32'(busy_cnt), (b == '0) ? 32'd0 : 32'(N));
    chk($sformatf("busy_in_done %0d/%0d", a, b), 32'(bus.busy), 32'd0);
    chk($sformatf("quotient %0d/%0d", a, b), 32'(bus.quotient), 32'(eq));
    chk($sformatf("remainder %0d/%0d", a, b), 32'(bus.remainder), 32'(er));
    chk($sformatf("div_by_zero %0d/%0d", a, b), 32'(bus.div_by_zero), 32'(ez));
    last_q = eq;
    last_r = er;
  endtask

  // One idle cycle after a result: done must have dropped, result must hold.
  task automatic idle_check();
    step();
    chk("done_pulse", 32'(bus.done), 32'd0);
    chk("quotient_hold", 32'(bus.quotient), 32'(last_q));
    chk("remainder_hold", 32'(bus.remainder), 32'(last_r));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] a, b;
    n_total = 0;
    n_pass  = 0;
    rst_n = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_quotient", 32'(bus.quotient), 32'd0);
    chk("rst_remainder", 32'(bus.remainder), 32'd0);
    chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", 32'(bus.busy), 32'd0);

    issue(8'd100, 8'd7);  wait_result(8'd100, 8'd7, -1);  idle_check();

    // Back-to-back: second start presented during the done cycle.
    issue(8'd255, 8'd1);  wait_result(8'd255, 8'd1, -1);
    issue(8'd0, 8'd9);    wait_result(8'd0, 8'd9, -1);    idle_check();

    issue(8'd5, 8'd0);    wait_result(8'd5, 8'd0, -1);    idle_check();
    issue(8'd9, 8'd3);    wait_result(8'd9, 8'd3, -1);    idle_check();

    issue(8'd3, 8'd200);  wait_result(8'd3, 8'd200, -1);  idle_check();
    issue(8'd200, 8'd3);  wait_result(8'd200, 8'd3, -1);  idle_check();

    issue(8'd100, 8'd7);  wait_result(8'd100, 8'd7, 3);   idle_check();

    // Abort in the fourth CALC cycle: everything clears at once, no done follows.
    issue(8'd100, 8'd7);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_quotient", 32'(bus.quotient), 32'd0);
    chk("abort_remainder", 32'(bus.remainder), 32'd0);
    chk("abort_dbz", 32'(bus.div_by_zero), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_done", 32'(bus.done), 32'd0);
    end
    rst_n = 1'b1;
    step();
    issue(8'd100, 8'd7);  wait_result(8'd100, 8'd7, -1);

    for (int k = 0; k < 40; k++) begin
      int sel;
      if ($urandom_range(0, 1) == 0) idle_check();
      a   = 8'($urandom_range(0, 255));
      sel = int'($urandom_range(0, 9));
      if (sel == 0)     b = 8'd0;
      else if (sel < 4) b = 8'($urandom_range(1, 15));
      else              b = 8'($urandom_range(1, 255));
      issue(a, b);
      wait_result(a, b, -1);
    end
    idle_check();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
